// File: rtl/mesi_snoop_ctrl_if.sv
// Snoop bus, receptor, local-write and memory write-back signals.
// slave: controller side; master: bus/receptor/memory side.
interface mesi_snoop_ctrl_if #(
  parameter int LINES  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
);
  localparam int IDX_W = $clog2(LINES);
  localparam int AW    = TAG_W + IDX_W;

  logic              bus_valid;
  logic              bus_ready;
  logic [1:0]        bus_msg;
  logic [AW-1:0]     bus_addr;
  logic              bus_done;
  logic              bus_hit;
  logic              bus_abort;
  logic              rcv_valid;
  logic [1:0]        rcv_estado;
  logic [1:0]        rcv_msg;
  logic [1:0]        rcv_estado_next;
  logic              rcv_wb;
  logic              rcv_abt;
  logic              loc_we;
  logic              loc_ready;
  logic [IDX_W-1:0]  loc_idx;
  logic [TAG_W-1:0]  loc_tag;
  logic [1:0]        loc_estado;
  logic [DATA_W-1:0] loc_data;
  logic              mem_wr_req;
  logic [AW-1:0]     mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ack;

  modport slave (
    input  bus_valid, bus_msg, bus_addr,
    output bus_ready, bus_done, bus_hit, bus_abort,
    output rcv_valid, rcv_estado, rcv_msg,
    input  rcv_estado_next, rcv_wb, rcv_abt,
    input  loc_we, loc_idx, loc_tag, loc_estado, loc_data,
    output loc_ready,
    output mem_wr_req, mem_wr_addr, mem_wr_data,
    input  mem_wr_ack
  );

  modport master (
    output bus_valid, bus_msg, bus_addr,
    input  bus_ready, bus_done, bus_hit, bus_abort,
    input  rcv_valid, rcv_estado, rcv_msg,
    output rcv_estado_next, rcv_wb, rcv_abt,
    output loc_we, loc_idx, loc_tag, loc_estado, loc_data,
    input  loc_ready,
    input  mem_wr_req, mem_wr_addr, mem_wr_data,
    output mem_wr_ack
  );
endinterface

// File: rtl/mesi_snoop_ctrl.sv
// MESI snoop controller: line array, receptor query, write-back.
// Ports: clock, reset_n (async low), sif (mesi_snoop_ctrl_if.slave).
module mesi_snoop_ctrl #(
  parameter int LINES  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
) (
  input logic               clock,
  input logic               reset_n,
  mesi_snoop_ctrl_if.slave  sif
);
  localparam int IDX_W = $clog2(LINES);
  localparam int AW    = TAG_W + IDX_W;
  localparam logic [1:0] ST_I = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE, S_LOOKUP, S_WB, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [1:0]        r_msg;
  logic [AW-1:0]     r_addr;
  logic [1:0]        r_nxt;
  logic              r_hit;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [1:0]        r_st   [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_rel;
  logic              w_wb;

  assign w_idx = r_addr[IDX_W-1:0];
  assign w_tag = r_addr[AW-1:IDX_W];
  assign w_hit = (r_tag[w_idx] == w_tag) &&
                 (r_st[w_idx] != ST_I);
  // rm (01) and wm (11) are the only messages the receptor acts on
  assign w_rel = w_hit & r_msg[0];
  // an abort always needs the line written back first
  assign w_wb  = sif.rcv_wb | sif.rcv_abt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    sif.bus_ready   = 1'b0;
    sif.loc_ready   = 1'b0;
    sif.bus_done    = 1'b0;
    sif.bus_hit     = 1'b0;
    sif.bus_abort   = 1'b0;
    sif.rcv_valid   = 1'b0;
    sif.rcv_estado  = ST_I;
    sif.rcv_msg     = 2'b00;
    sif.mem_wr_req  = 1'b0;
    sif.mem_wr_addr = '0;
    sif.mem_wr_data = '0;
    case (r_state)
      S_IDLE: begin
        sif.bus_ready = 1'b1;
        sif.loc_ready = 1'b1;
        if (sif.bus_valid) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        w_next = S_DONE;
        if (w_rel) begin
          sif.rcv_valid  = 1'b1;
          sif.rcv_estado = r_st[w_idx];
          sif.rcv_msg    = r_msg;
          if (w_wb) w_next = S_WB;
        end
      end
      S_WB: begin
        sif.mem_wr_req  = 1'b1;
        sif.bus_abort   = 1'b1;
        sif.mem_wr_addr = {r_tag[w_idx], w_idx};
        sif.mem_wr_data = r_data[w_idx];
        if (sif.mem_wr_ack) w_next = S_DONE;
      end
      S_DONE: begin
        sif.bus_done = 1'b1;
        sif.bus_hit  = r_hit;
        w_next       = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_msg  <= '0;
      r_addr <= '0;
      r_nxt  <= ST_I;
      r_hit  <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        r_tag[i]  <= '0;
        r_st[i]   <= ST_I;
        r_data[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sif.bus_valid) begin
            r_msg  <= sif.bus_msg;
            r_addr <= sif.bus_addr;
          end
          if (sif.loc_we) begin
            r_tag[sif.loc_idx]  <= sif.loc_tag;
            r_st[sif.loc_idx]   <= sif.loc_estado;
            r_data[sif.loc_idx] <= sif.loc_data;
          end
        end
        S_LOOKUP: begin
          r_hit <= w_hit;
          if (w_rel) begin
            if (w_wb) r_nxt <= sif.rcv_estado_next;
            else      r_st[w_idx] <= sif.rcv_estado_next;
          end
        end
        S_WB: begin
          if (sif.mem_wr_ack) r_st[w_idx] <= r_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mesi_snoop_ctrl.md
# mesi_snoop_ctrl

Per-cache snoop controller sitting directly upstream of the MESI receptor logic. It holds a small direct-mapped array of line tags, MESI states and data, and accepts snooped bus messages from other caches. For each relevant snoop it presents the line's current state and the message to the receptor, then commits the returned next state. When the receptor requests a write-back, it runs the memory write handshake and raises the memory-access abort.

## Interface
- LINES, 4: number of cache lines, a power of two; IDX_W = log2(LINES)
- TAG_W, 4: tag width; full address width is TAG_W+IDX_W, with the tag in the MSBs
- DATA_W, 8: data bits per line

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- bus_valid  in  1  snoop message present
- bus_ready  out  1  controller can accept a snoop
- bus_msg  in  2  00 rh, 01 rm, 10 wh, 11 wm
- bus_addr  in  TAG_W+IDX_W  snooped address
- bus_done  out  1  one-cycle pulse when a snoop completes
- bus_hit  out  1  valid with bus_done: tag matched and the line was not I
- bus_abort  out  1  level: memory must hold off the requester's access
- rcv_valid  out  1  rcv_estado/rcv_msg are meaningful
- rcv_estado  out  2  line state to receptor: 00 M, 01 E, 10 S, 11 I
- rcv_msg  out  2  message to receptor
- rcv_estado_next  in  2  receptor next state
- rcv_wb  in  1  receptor write-back request
- rcv_abt  in  1  receptor abort request
- loc_we  in  1  local cache writes one line
- loc_ready  out  1  local write accepted this cycle
- loc_idx  in  IDX_W  line index for the local write
- loc_tag  in  TAG_W  tag for the local write
- loc_estado  in  2  state for the local write
- loc_data  in  DATA_W  data for the local write
- mem_wr_req  out  1  write-back request
- mem_wr_addr  out  TAG_W+IDX_W  {stored tag, idx}
- mem_wr_data  out  DATA_W  line data
- mem_wr_ack  in  1  memory accepted the write

## Operation
- FSM states: IDLE, LOOKUP, WB, DONE.
- IDLE:
  - bus_ready=1 and loc_ready=1.
  - A snoop is accepted on bus_valid & bus_ready; msg and addr are registered, then the FSM goes to LOOKUP.
  - loc_we writes tag, state and data to line loc_idx.
  - A local write and a snoop accepted in the same cycle are both taken; LOOKUP sees the updated line.
- LOOKUP:
  - hit = stored tag equals the addr tag and stored state != I.
  - relevant = hit and msg ∈ {rm, wm}.
  - Not relevant (miss, I, rh or wh): rcv_valid=0, no array change, go to DONE with bus_hit=hit.
  - Relevant: rcv_valid=1, rcv_estado=stored state, rcv_msg=msg. Sample the rcv_* inputs at the clock edge.
    - rcv_wb=1: latch rcv_estado_next, go to WB, assert bus_abort.
    - rcv_wb=0: write rcv_estado_next to the line, go to DONE.
- rcv_abt=1 with rcv_wb=0 is treated as rcv_wb=1 (abort always implies a write-back). rcv_estado_next is ignored when rcv_valid=0.
- WB:
  - mem_wr_req=1, mem_wr_addr and mem_wr_data held stable, bus_abort=1.
  - On mem_wr_ack: write the latched state to the line, go to DONE.
  - mem_wr_ack outside WB is ignored.
- DONE: bus_done=1 for one cycle, bus_abort drops, bus_hit valid. Next state IDLE.
- loc_ready=0 in LOOKUP, WB and DONE; loc_we is ignored there, and the local side must retry.
- rcv_valid=0 outside LOOKUP, with rcv_estado=11 and rcv_msg=00 so the receptor never sees a stale pair.
- Line data is never modified by snoops; only states change.

## Timing
- Reset (asynchronous, immediate):
  - FSM to IDLE; all line states to I; tags and data to 0.
  - bus_ready=1, loc_ready=1; every other output 0, except rcv_estado=11.
  - Reset during WB drops mem_wr_req and bus_abort at once. No state commit occurs.
- Snoop accepted at edge 0:
  - LOOKUP in cycle 1.
  - No write-back: DONE in cycle 2. The new state is visible from cycle 2, and the next snoop can be accepted at the end of cycle 3.
  - Write-back: WB from cycle 2, mem_wr_req and bus_abort high from cycle 2. An ack in cycle k gives DONE in cycle k+1 and the commit at that edge.
- Back-to-back snoops have a throughput of one per 3 cycles minimum.

## Test plan
- Reset, local write idx1 tag 5 state E, snoop rm addr {5,1} -> rcv_estado=01, rcv_msg=01 in cycle 1; next state S; bus_done with bus_hit=1 in cycle 2; no mem_wr_req.
- Line idx2 tag 3 state M, snoop wm, receptor returns wb=1/next I, ack held off 3 cycles -> mem_wr_req and bus_abort high 4 cycles, addr {3,2}, data correct; state I after ack; bus_done one cycle later.
- Snoop rm with tag mismatch, and snoop wh on a valid line -> rcv_valid stays 0, state unchanged, bus_done with bus_hit=0 and 1 respectively.
- Snoop on a line in I -> no receptor query, bus_hit=0, state stays I.
- loc_we asserted during WB -> loc_ready=0, array unchanged. Same-cycle loc_we (S→M) and snoop accepted in IDLE -> LOOKUP sees M and a write-back occurs.
- reset_n pulsed low mid-WB -> mem_wr_req drops in the same cycle; all lines I; bus_ready=1 after release.
